// File: rtl/gcc_point_feeder_if.sv
// Host-side and core-side signal bundle of the gravity-centre point feeder.
// The feeder connects through the slave modport; the host/core side uses master.
interface gcc_point_feeder_if;
    logic       wr_en;
    logic [7:0] wr_x;
    logic [7:0] wr_y;
    logic [3:0] wr_w;
    logic       wr_full;
    logic       start;
    logic       busy;
    logic       core_rst_n;
    logic [7:0] xi;
    logic [7:0] yi;
    logic [3:0] wi;
    logic       ready_n;
    logic [7:0] xc;
    logic [7:0] yc;
    logic       res_valid;
    logic [7:0] res_x;
    logic [7:0] res_y;
    logic [3:0] res_idx;
    logic       done;
    logic       err_ready;

    modport master (
        output wr_en, wr_x, wr_y, wr_w, start, ready_n, xc, yc,
        input  wr_full, busy, core_rst_n, xi, yi, wi,
               res_valid, res_x, res_y, res_idx, done, err_ready
    );

    modport slave (
        input  wr_en, wr_x, wr_y, wr_w, start, ready_n, xc, yc,
        output wr_full, busy, core_rst_n, xi, yi, wi,
               res_valid, res_x, res_y, res_idx, done, err_ready
    );
endinterface

// File: rtl/gcc_point_feeder.sv
// Buffers host points, resets the gravity-centre core, streams the points into it
// and returns each full-window centroid tagged with the index of the point that produced it.
module gcc_point_feeder #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned SKIP    = 5,
    parameter int unsigned RES_LAT = 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    gcc_point_feeder_if.slave  io_bus
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned IW = $clog2(DEPTH);

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic [3:0] w;
    } point_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CRST   = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [CW-1:0]               r_count;
    logic [CW-1:0]               w_count_nxt;
    logic [CW-1:0]               r_k;
    logic [CW-1:0]               w_k_nxt;
    point_t                      r_buf [DEPTH];
    point_t                      r_pt;
    point_t                      w_pt_nxt;
    logic                        r_wr_full;
    logic                        r_busy;
    logic                        w_busy_nxt;
    logic                        r_core_rst_n;
    logic                        w_core_rst_n_nxt;
    logic                        r_done;
    logic                        w_done_nxt;
    logic                        w_wr_acc;
    logic                        w_start_acc;
    logic [RES_LAT-1:0]          r_tag_v;
    logic [RES_LAT-1:0][IW-1:0]  r_tag_idx;
    logic [RES_LAT:0]            w_tag_v_ext;
    logic [RES_LAT:0][IW-1:0]    w_tag_idx_ext;
    logic                        r_res_valid;
    logic [7:0]                  r_res_x;
    logic [7:0]                  r_res_y;
    logic [3:0]                  r_res_idx;
    logic                        r_err_ready;

    assign w_wr_acc    = (r_state == S_IDLE) && io_bus.wr_en && (r_count < CW'(DEPTH));
    assign w_start_acc = (r_state == S_IDLE) && io_bus.start && ((r_count != '0) || w_wr_acc);

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_start_acc) w_state_nxt = S_CRST;
            S_CRST:   w_state_nxt = S_STREAM;
            S_STREAM: if (r_k == r_count - CW'(1)) w_state_nxt = S_DRAIN;
            S_DRAIN:  if (r_k == CW'(RES_LAT - 1)) w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Output values are derived from the next state so the registers line up with the state.
    always_comb begin
        w_count_nxt      = r_count;
        w_k_nxt          = '0;
        w_pt_nxt         = '0;
        w_busy_nxt       = (w_state_nxt != S_IDLE);
        w_core_rst_n_nxt = (w_state_nxt != S_CRST);
        w_done_nxt       = (w_state_nxt == S_DONE);
        if (w_wr_acc)           w_count_nxt = r_count + CW'(1);
        if (r_state == S_DONE)  w_count_nxt = '0;
        case (w_state_nxt)
            S_STREAM: w_k_nxt = (r_state == S_STREAM) ? r_k + CW'(1) : '0;
            S_DRAIN:  w_k_nxt = (r_state == S_DRAIN)  ? r_k + CW'(1) : '0;
            default:  w_k_nxt = '0;
        endcase
        if (w_state_nxt == S_STREAM) w_pt_nxt = r_buf[w_k_nxt[IW-1:0]];
    end

    always_ff @(posedge i_clk) begin
        if (w_wr_acc && !i_rst)
            r_buf[r_count[IW-1:0]] <= '{x: io_bus.wr_x, y: io_bus.wr_y, w: io_bus.wr_w};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count      <= '0;
            r_k          <= '0;
            r_pt         <= '0;
            r_wr_full    <= 1'b0;
            r_busy       <= 1'b0;
            r_core_rst_n <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_count      <= w_count_nxt;
            r_k          <= w_k_nxt;
            r_pt         <= w_pt_nxt;
            r_wr_full    <= (w_count_nxt == CW'(DEPTH));
            r_busy       <= w_busy_nxt;
            r_core_rst_n <= w_core_rst_n_nxt;
            r_done       <= w_done_nxt;
        end
    end

    // Tag pipeline: the top slot marks the edge at which Xc/Yc belong to that point.
    assign w_tag_v_ext   = {r_tag_v, (r_state == S_STREAM) && (r_k >= CW'(SKIP))};
    assign w_tag_idx_ext = {r_tag_idx, r_k[IW-1:0]};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tag_v     <= '0;
            r_tag_idx   <= '0;
            r_res_valid <= 1'b0;
            r_res_x     <= '0;
            r_res_y     <= '0;
            r_res_idx   <= '0;
            r_err_ready <= 1'b0;
        end else begin
            r_tag_v     <= w_tag_v_ext[RES_LAT-1:0];
            r_tag_idx   <= w_tag_idx_ext[RES_LAT-1:0];
            r_res_valid <= w_tag_v_ext[RES_LAT];
            if (w_tag_v_ext[RES_LAT]) begin
                r_res_x   <= io_bus.xc;
                r_res_y   <= io_bus.yc;
                r_res_idx <= 4'(w_tag_idx_ext[RES_LAT]);
            end
            if (w_start_acc)
                r_err_ready <= 1'b0;
            else if (w_tag_v_ext[RES_LAT] && io_bus.ready_n)
                r_err_ready <= 1'b1;
        end
    end

    assign io_bus.wr_full    = r_wr_full;
    assign io_bus.busy       = r_busy;
    assign io_bus.core_rst_n = r_core_rst_n;
    assign io_bus.xi         = r_pt.x;
    assign io_bus.yi         = r_pt.y;
    assign io_bus.wi         = r_pt.w;
    assign io_bus.res_valid  = r_res_valid;
    assign io_bus.res_x      = r_res_x;
    assign io_bus.res_y      = r_res_y;
    assign io_bus.res_idx    = r_res_idx;
    assign io_bus.done       = r_done;
    assign io_bus.err_ready  = r_err_ready;
endmodule
